// File: rtl/sqrt_pkg.sv
// Shared types and constants for the shared square-root engine arbiter.
// Number format is 16-bit {sign, exp[7:0], mant[6:0]}.
package sqrt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        RESP,
        COOL
    } state_t;

    localparam int SIGN_BIT = 15;
    localparam int EXP_MSB  = 14;
    localparam int EXP_LSB  = 7;
    localparam int MANT_W   = 7;
    localparam int EXP_W    = EXP_MSB - EXP_LSB + 1;
    localparam int FP_W     = 1 + EXP_W + MANT_W;

    localparam logic [FP_W-1:0] QNAN     = 16'h7FC0;
    localparam logic [FP_W-1:0] POS_ZERO = 16'h0000;
    localparam logic [FP_W-1:0] NEG_ZERO = 16'h8000;

    typedef enum logic [1:0] {
        CLS_POS_ZERO,
        CLS_NEG_ZERO,
        CLS_NEGATIVE,
        CLS_ENGINE
    } op_class_t;

    // Zero and denormal operands keep their sign; any other negative value is invalid.
    function automatic op_class_t classify(input logic sign, input logic [EXP_W-1:0] exp);
        if (exp == '0) begin
            return sign ? CLS_NEG_ZERO : CLS_POS_ZERO;
        end
        if (sign) begin
            return CLS_NEGATIVE;
        end
        return CLS_ENGINE;
    endfunction

endpackage

// File: rtl/sqrt_req_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or after last_grant+1,
// wrapping around, as a one-hot grant plus its index.
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last_grant,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_idx,
    output logic             any
);

    localparam logic [ID_W:0] N_L = (ID_W + 1)'(N_REQ);

    logic [ID_W-1:0]  cand_idx  [N_REQ];
    logic [N_REQ-1:0] cand_req;
    logic [N_REQ-1:0] first;
    logic [N_REQ-1:0] grant_acc [N_REQ];
    logic [ID_W-1:0]  idx_acc   [N_REQ];

    // Candidate gi is the requester gi+1 positions after the last grant.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
        logic [ID_W:0] sum;
        assign sum          = {1'b0, last_grant} + (ID_W + 1)'(gi + 1);
        assign cand_idx[gi] = (sum >= N_L) ? ID_W'(sum - N_L) : ID_W'(sum);
        assign cand_req[gi] = req[cand_idx[gi]];

        if (gi == 0) begin : g_head
            assign first[gi]     = cand_req[gi];
            assign grant_acc[gi] = first[gi] ? (N_REQ'(1) << cand_idx[gi]) : '0;
            assign idx_acc[gi]   = first[gi] ? cand_idx[gi] : '0;
        end else begin : g_tail
            assign first[gi]     = cand_req[gi] & ~|cand_req[gi-1:0];
            assign grant_acc[gi] = grant_acc[gi-1] |
                                   (first[gi] ? (N_REQ'(1) << cand_idx[gi]) : '0);
            assign idx_acc[gi]   = idx_acc[gi-1] | (first[gi] ? cand_idx[gi] : '0);
        end
    end

    assign grant     = grant_acc[N_REQ-1];
    assign grant_idx = idx_acc[N_REQ-1];
    assign any       = |req;

endmodule

// File: rtl/sqrt_req_arbiter.sv
// Shares one sqrt engine between N_REQ requesters: round-robin grant, trivial
// operand bypass, completion watchdog and a tagged valid/ready response.
module sqrt_req_arbiter
    import sqrt_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 15,
    parameter int ID_W    = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*FP_W-1:0]   req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [FP_W-1:0]         rsp_data,
    output logic                    rsp_error,
    output logic                    rsp_timeout,
    output logic                    eng_start,
    output logic [FP_W-1:0]         eng_num,
    input  logic [FP_W-1:0]         eng_num_o,
    input  logic                    eng_valid,
    input  logic                    eng_error,
    output logic                    eng_rst,
    output logic                    busy
);

    localparam int              TMR_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    state_t            state_reg, state_next;
    logic [ID_W-1:0]   last_grant_reg;
    logic [ID_W-1:0]   id_reg;
    logic [FP_W-1:0]   operand_reg;
    logic [FP_W-1:0]   rsp_data_reg;
    logic              rsp_error_reg;
    logic              rsp_timeout_reg;
    logic [TMR_W-1:0]  timer_reg;

    logic [N_REQ-1:0]  grant;
    logic [ID_W-1:0]   grant_idx;
    logic              grant_any;
    logic [FP_W-1:0]   req_word [N_REQ];
    logic [FP_W-1:0]   sel_op;
    op_class_t         sel_class;
    logic              accept;
    logic              in_wait;
    logic              timer_expired;
    logic              abort;

    rr_picker #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_picker (
        .req        (req_valid),
        .last_grant (last_grant_reg),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .any        (grant_any)
    );

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_word
        assign req_word[gi] = req_data[FP_W*gi +: FP_W];
    end

    assign sel_op        = req_word[grant_idx];
    assign sel_class     = classify(sel_op[SIGN_BIT], sel_op[EXP_MSB:EXP_LSB]);
    assign accept        = (state_reg == IDLE) && grant_any;
    assign in_wait       = (state_reg == WAIT);
    assign timer_expired = in_wait && (timer_reg == TMR_LAST);
    // A completion pulse on the last allowed cycle still counts as on time.
    assign abort         = timer_expired && !eng_valid && !eng_error;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: begin
                if (grant_any) begin
                    state_next = (sel_class == CLS_ENGINE) ? START : RESP;
                end
            end
            START: state_next = WAIT;
            WAIT: begin
                if (eng_error || eng_valid || timer_expired) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = COOL;
                end
            end
            COOL:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (accept && !rst) ? grant : '0;
        rsp_valid = (state_reg == RESP);
        eng_start = (state_reg == START);
        busy      = (state_reg != IDLE);
        eng_rst   = rst || abort;
    end

    assign rsp_id      = id_reg;
    assign rsp_data    = rsp_data_reg;
    assign rsp_error   = rsp_error_reg;
    assign rsp_timeout = rsp_timeout_reg;
    assign eng_num     = operand_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_reg  <= ID_W'(N_REQ - 1);
            id_reg          <= '0;
            operand_reg     <= '0;
            rsp_data_reg    <= '0;
            rsp_error_reg   <= 1'b0;
            rsp_timeout_reg <= 1'b0;
            timer_reg       <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_any) begin
                        last_grant_reg <= grant_idx;
                        id_reg         <= grant_idx;
                        operand_reg    <= sel_op;
                        case (sel_class)
                            CLS_POS_ZERO: rsp_data_reg <= POS_ZERO;
                            CLS_NEG_ZERO: rsp_data_reg <= NEG_ZERO;
                            CLS_NEGATIVE: begin
                                rsp_data_reg  <= QNAN;
                                rsp_error_reg <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                START: timer_reg <= '0;
                WAIT: begin
                    timer_reg <= timer_reg + 1'b1;
                    if (eng_error) begin
                        rsp_data_reg  <= QNAN;
                        rsp_error_reg <= 1'b1;
                    end else if (eng_valid) begin
                        rsp_data_reg <= eng_num_o;
                    end else if (timer_expired) begin
                        rsp_data_reg    <= QNAN;
                        rsp_timeout_reg <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_error_reg   <= 1'b0;
                        rsp_timeout_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sqrt_req_arbiter.sv
// Self-checking bench for sqrt_req_arbiter with a behavioural engine of
// configurable latency and reply mode, plus a round-robin/result reference model.
module tb_sqrt_req_arbiter;

    localparam int N  = 4;
    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [63:0] req_data = '0;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_data;
    logic        rsp_error;
    logic        rsp_timeout;
    logic        eng_start;
    logic [15:0] eng_num;
    logic [15:0] eng_num_o = '0;
    logic        eng_valid = 1'b0;
    logic        eng_error = 1'b0;
    logic        eng_rst;
    logic        busy;

    sqrt_req_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_error(rsp_error),
        .rsp_timeout(rsp_timeout), .eng_start(eng_start), .eng_num(eng_num),
        .eng_num_o(eng_num_o), .eng_valid(eng_valid), .eng_error(eng_error),
        .eng_rst(eng_rst), .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // engine model: 0 = valid after lat, 1 = valid+error together, 2 = silent
    int          eng_lat = 7;
    int          eng_mode = 0;
    bit          eng_pend = 0;
    int          eng_cnt = 0;
    logic [15:0] eng_op = '0;

    int rr_last = N - 1;

    typedef struct {
        int          acc_cyc;
        int          gidx;
        logic [3:0]  vmask;
        logic [15:0] op;
        int          starts;
        int          start_cyc;
        logic [15:0] start_num;
        int          rsp_cyc;
        logic [1:0]  id;
        logic [15:0] data;
        logic        err;
        logic        to;
        int          rst_pulses;
        int          busy_bad;
        bit          timed_out;
    } job_t;

    function automatic logic [15:0] model_sqrt(input logic [15:0] x);
        if (x == 16'h4080) return 16'h4000;
        return {1'b0, x[14:0]} ^ 16'h0155;
    endfunction

    // Expected response from the operand class and the engine's behaviour.
    function automatic void ref_result(input logic [15:0] op, input int mode,
                                       output logic [15:0] d, output logic e,
                                       output logic t, output bit uses_eng);
        e = 1'b0; t = 1'b0; uses_eng = 1'b0;
        if (op[14:7] == 8'd0) begin
            d = op[15] ? 16'h8000 : 16'h0000;
        end else if (op[15]) begin
            d = 16'h7FC0; e = 1'b1;
        end else begin
            uses_eng = 1'b1;
            if (mode == 0) d = model_sqrt(op);
            else if (mode == 1) begin d = 16'h7FC0; e = 1'b1; end
            else begin d = 16'h7FC0; t = 1'b1; end
        end
    endfunction

    function automatic int rr_next(input logic [3:0] v);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (rr_last + k) % N;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    // Advance to the next negedge, run the engine model, let outputs settle.
    task automatic cycle();
        @(negedge clk);
        cyc++;
        eng_valid = 1'b0;
        eng_error = 1'b0;
        if (rst) begin
            eng_pend = 0;
        end else if (eng_start) begin
            eng_pend = 1; eng_cnt = eng_lat; eng_op = eng_num;
        end else if (eng_pend) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
                eng_pend = 0;
                if (eng_mode == 0) begin
                    eng_valid = 1'b1; eng_num_o = model_sqrt(eng_op);
                end else if (eng_mode == 1) begin
                    eng_valid = 1'b1; eng_error = 1'b1; eng_num_o = model_sqrt(eng_op);
                end
            end
        end
        #1;
    endtask

    // Observe one job from grant to (optionally) handshake; returns in IDLE when hs=1.
    task automatic collect(output job_t j, input bit keep, input bit hs);
        int drop;
        j = '{default: 0};
        j.acc_cyc = -1;
        drop = -1;
        #1;
        for (int n = 0; n < 200; n++) begin
            if (j.acc_cyc < 0) begin
                if (req_ready != 0) begin
                    j.acc_cyc = cyc;
                    j.vmask = req_valid;
                    if ($countones(req_ready) != 1) j.busy_bad++;
                    for (int i = 0; i < N; i++) if (req_ready[i]) j.gidx = i;
                    j.op = req_data[16*j.gidx +: 16];
                    if (!keep) drop = j.gidx;
                end
            end else begin
                if (!busy) j.busy_bad++;
                if (eng_start) begin j.starts++; j.start_cyc = cyc; j.start_num = eng_num; end
                if (eng_rst) j.rst_pulses++;
                if (rsp_valid) begin
                    j.rsp_cyc = cyc; j.id = rsp_id; j.data = rsp_data;
                    j.err = rsp_error; j.to = rsp_timeout;
                    $display("job req=%0d op=%h id=%0d data=%h err=%b to=%b lat=%0d",
                             j.gidx, j.op, j.id, j.data, j.err, j.to, j.rsp_cyc - j.acc_cyc);
                    if (!hs) return;
                    cycle();
                    if (!busy) j.busy_bad++;
                    cycle();
                    return;
                end
            end
            cycle();
            if (drop >= 0) begin req_valid[drop] = 1'b0; drop = -1; end
        end
        j.timed_out = 1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '0;
        repeat (3) cycle();
        checks++;
        if ({req_ready, rsp_valid, rsp_id, rsp_data, rsp_error, rsp_timeout,
             eng_start, eng_num, busy} !== 43'd0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b v=%b id=%0d d=%h e=%b t=%b st=%b num=%h busy=%b expected all zero",
                     req_ready, rsp_valid, rsp_id, rsp_data, rsp_error, rsp_timeout, eng_start, eng_num, busy);
        end
        checks++;
        if (eng_rst !== 1'b1) begin errors++; $display("FAIL reset_eng_rst: got %b expected 1", eng_rst); end
        rst = 1'b0;
        cycle();
        checks++;
        if ({eng_rst, busy} !== 2'b00) begin errors++; $display("FAIL reset_release: got eng_rst=%b busy=%b expected 0 0", eng_rst, busy); end
        rr_last = N - 1;
    endtask

    task automatic test_single();
        job_t j;
        eng_mode = 0; eng_lat = 7;
        req_data[15:0] = 16'h4080;
        req_valid = 4'b0001;
        collect(j, 0, 1);
        checks++;
        if (j.timed_out || j.gidx != 0) begin errors++; $display("FAIL single_grant: got %0d (timeout=%0d) expected 0", j.gidx, j.timed_out); end
        checks++;
        if (j.starts != 1 || j.start_cyc != j.acc_cyc + 1 || j.start_num !== 16'h4080) begin
            errors++; $display("FAIL single_start: got n=%0d at +%0d num=%h expected 1 at +1 num=4080", j.starts, j.start_cyc - j.acc_cyc, j.start_num);
        end
        checks++;
        if (j.rsp_cyc != j.acc_cyc + 9) begin errors++; $display("FAIL single_latency: got %0d expected 9", j.rsp_cyc - j.acc_cyc); end
        checks++;
        if ({j.id, j.data, j.err, j.to} !== {2'd0, 16'h4000, 1'b0, 1'b0}) begin
            errors++; $display("FAIL single_rsp: got id=%0d d=%h e=%b t=%b expected 0 4000 0 0", j.id, j.data, j.err, j.to);
        end
        rr_last = 0;
    endtask

    task automatic test_fairness();
        job_t j;
        int exp_g;
        eng_mode = 0;
        for (int i = 0; i < N; i++) req_data[16*i +: 16] = {1'b0, 8'h80 + 8'(i), 7'h11 * 7'(i + 1)};
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            eng_lat = $urandom_range(1, 5);
            exp_g = rr_next(4'b1111);
            collect(j, 1, 1);
            checks++;
            if (j.timed_out || j.gidx != exp_g || j.gidx != (k + 1) % N) begin
                errors++; $display("FAIL fair_grant: got %0d expected %0d", j.gidx, exp_g);
            end
            checks++;
            if (j.starts != 1 || j.busy_bad != 0) begin
                errors++; $display("FAIL fair_single_start_busy: got starts=%0d busy_bad=%0d expected 1 0", j.starts, j.busy_bad);
            end
            checks++;
            if (j.data !== model_sqrt(j.op) || j.id !== 2'(exp_g)) begin
                errors++; $display("FAIL fair_rsp: got id=%0d d=%h expected id=%0d d=%h", j.id, j.data, exp_g, model_sqrt(j.op));
            end
            rr_last = j.gidx;
        end
        req_valid = '0;
    endtask

    task automatic test_bypass();
        logic [15:0] ops [3];
        logic [15:0] exp_d [3];
        logic        exp_e [3];
        job_t j;
        int r;
        ops   = '{16'h0000, 16'h8000, 16'hC080};
        exp_d = '{16'h0000, 16'h8000, 16'h7FC0};
        exp_e = '{1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 3; k++) begin
            r = $urandom_range(0, N - 1);
            req_data[16*r +: 16] = ops[k];
            req_valid = '0;
            req_valid[r] = 1'b1;
            collect(j, 0, 1);
            checks++;
            if (j.timed_out || j.rsp_cyc != j.acc_cyc + 1 || j.starts != 0) begin
                errors++; $display("FAIL bypass_timing: got lat=%0d starts=%0d expected 1 0", j.rsp_cyc - j.acc_cyc, j.starts);
            end
            checks++;
            if ({j.id, j.data, j.err, j.to} !== {2'(r), exp_d[k], exp_e[k], 1'b0}) begin
                errors++; $display("FAIL bypass_rsp: got id=%0d d=%h e=%b t=%b expected %0d %h %b 0", j.id, j.data, j.err, j.to, r, exp_d[k], exp_e[k]);
            end
            rr_last = r;
        end
    endtask

    task automatic test_collision();
        job_t j;
        eng_mode = 1; eng_lat = 3;
        req_data[32 +: 16] = 16'h4200;
        req_valid = 4'b0100;
        collect(j, 0, 1);
        checks++;
        if (j.timed_out || j.rsp_cyc != j.acc_cyc + 5 || {j.id, j.data, j.err, j.to} !== {2'd2, 16'h7FC0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL collision_rsp: got lat=%0d id=%0d d=%h e=%b t=%b expected 5 2 7fc0 1 0", j.rsp_cyc - j.acc_cyc, j.id, j.data, j.err, j.to);
        end
        rr_last = 2;
    endtask

    task automatic test_timeout();
        job_t j;
        eng_mode = 2; eng_lat = 4;
        req_data[16 +: 16] = 16'h3F80;
        req_valid = 4'b0010;
        collect(j, 0, 1);
        checks++;
        if (j.timed_out || j.rsp_cyc != j.start_cyc + 16) begin
            errors++; $display("FAIL timeout_latency: got %0d expected 16 after start", j.rsp_cyc - j.start_cyc);
        end
        checks++;
        if (j.rst_pulses != 1) begin errors++; $display("FAIL timeout_eng_rst: got %0d pulses expected 1", j.rst_pulses); end
        checks++;
        if ({j.id, j.data, j.err, j.to} !== {2'd1, 16'h7FC0, 1'b0, 1'b1}) begin
            errors++; $display("FAIL timeout_rsp: got id=%0d d=%h e=%b t=%b expected 1 7fc0 0 1", j.id, j.data, j.err, j.to);
        end
        rr_last = 1;
        eng_valid = 1'b1;
        eng_num_o = 16'h1234;
        for (int k = 0; k < 3; k++) begin
            cycle();
            checks++;
            if ({rsp_valid, busy, eng_start} !== 3'b000) begin
                errors++; $display("FAIL stray_valid: got v=%b busy=%b start=%b expected 0 0 0", rsp_valid, busy, eng_start);
            end
        end
        eng_mode = 0;
    endtask

    task automatic test_backpressure_reset();
        job_t j;
        bit seen;
        eng_mode = 0; eng_lat = 4;
        for (int i = 0; i < N; i++) req_data[16*i +: 16] = (i == 0) ? 16'h4080 : 16'h4100;
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        collect(j, 0, 0);
        checks++;
        if (j.timed_out || j.data !== 16'h4000) begin errors++; $display("FAIL hold_first: got d=%h expected 4000", j.data); end
        req_valid = 4'b1110;
        for (int k = 0; k < 10; k++) begin
            cycle();
            checks++;
            if ({rsp_valid, rsp_id, rsp_data, rsp_error, rsp_timeout, req_ready, eng_start} !==
                {1'b1, 2'd0, 16'h4000, 1'b0, 1'b0, 4'b0000, 1'b0}) begin
                errors++; $display("FAIL hold_stable: got v=%b id=%0d d=%h e=%b t=%b rdy=%b st=%b expected 1 0 4000 0 0 0000 0",
                                   rsp_valid, rsp_id, rsp_data, rsp_error, rsp_timeout, req_ready, eng_start);
            end
        end
        rsp_ready = 1'b1;
        req_valid = '0;
        cycle();
        cycle();
        rr_last = 0;
        eng_mode = 2;
        req_data[32 +: 16] = 16'h4400;
        req_valid = 4'b0100;
        seen = 0;
        for (int n = 0; n < 10 && !seen; n++) begin
            cycle();
            if (eng_start) seen = 1;
        end
        req_valid = '0;
        checks++;
        if (!seen) begin errors++; $display("FAIL rst_job_start: got no eng_start expected one"); end
        cycle();
        cycle();
        rst = 1'b1;
        #1;
        checks++;
        if ({eng_rst, busy} !== 2'b11) begin errors++; $display("FAIL rst_in_wait: got eng_rst=%b busy=%b expected 1 1", eng_rst, busy); end
        cycle();
        rst = 1'b0;
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_id, rsp_data, rsp_error, rsp_timeout,
             eng_start, eng_num, busy, eng_rst} !== 44'd0) begin
            errors++; $display("FAIL rst_outputs: got rdy=%b v=%b id=%0d d=%h e=%b t=%b st=%b num=%h busy=%b erst=%b expected all zero",
                               req_ready, rsp_valid, rsp_id, rsp_data, rsp_error, rsp_timeout, eng_start, eng_num, busy, eng_rst);
        end
        rr_last = N - 1;
        eng_mode = 0;
        req_valid = 4'b1111;
        collect(j, 0, 1);
        req_valid = '0;
        checks++;
        if (j.timed_out || j.gidx != 0 || j.data !== 16'h4000) begin
            errors++; $display("FAIL rst_next_grant: got %0d d=%h expected 0 4000", j.gidx, j.data);
        end
        rr_last = 0;
    endtask

    task automatic test_random();
        job_t j;
        logic [3:0]  mask;
        logic [15:0] op;
        logic [15:0] ed;
        logic        ee, et;
        bit          ue;
        int          eg, sel;
        for (int k = 0; k < 24; k++) begin
            mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < N; i++) begin
                sel = $urandom_range(0, 9);
                if (sel == 0) op = {1'($urandom), 8'h00, 7'($urandom)};
                else if (sel == 1) op = {1'b1, 8'($urandom_range(1, 255)), 7'($urandom)};
                else op = {1'b0, 8'($urandom_range(1, 255)), 7'($urandom)};
                req_data[16*i +: 16] = op;
            end
            eng_mode = ($urandom_range(0, 9) < 2) ? 2 : $urandom_range(0, 1);
            eng_lat = $urandom_range(1, 12);
            eg = rr_next(mask);
            req_valid = mask;
            collect(j, 0, 1);
            ref_result(req_data[16*eg +: 16], eng_mode, ed, ee, et, ue);
            checks++;
            if (j.timed_out || j.gidx != eg || j.id !== 2'(eg)) begin
                errors++; $display("FAIL rand_grant: got %0d/%0d expected %0d", j.gidx, j.id, eg);
            end
            checks++;
            if ({j.data, j.err, j.to} !== {ed, ee, et}) begin
                errors++; $display("FAIL rand_rsp: got d=%h e=%b t=%b expected %h %b %b", j.data, j.err, j.to, ed, ee, et);
            end
            checks++;
            if (j.starts != (ue ? 1 : 0) || j.busy_bad != 0 ||
                (!ue && j.rsp_cyc != j.acc_cyc + 1) ||
                (ue && eng_mode != 2 && j.rsp_cyc != j.acc_cyc + 2 + eng_lat) ||
                (ue && eng_mode == 2 && (j.rsp_cyc != j.start_cyc + 16 || j.rst_pulses != 1))) begin
                errors++; $display("FAIL rand_timing: got lat=%0d starts=%0d rstp=%0d busy_bad=%0d expected eng=%0d mode=%0d L=%0d",
                                   j.rsp_cyc - j.acc_cyc, j.starts, j.rst_pulses, j.busy_bad, ue, eng_mode, eng_lat);
            end
            rr_last = j.gidx;
            req_valid = '0;
        end
        eng_mode = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_bypass();
        test_collision();
        test_timeout();
        test_backpressure_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench time limit");
    end

endmodule
